// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: one-access-per-cycle arbiter for memory_controller with     |
// | locked bursts and in-order read-return routing. MEM_ARB_RR_EN: rr search.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REQ      = 3,
  parameter int READ_LATENCY = 2,
  parameter int LOCK_MAX     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             boot_done,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               we,
  input  logic [NUM_REQ-1:0]               lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             lock_timeout,
  output logic                             err,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_re,
  output logic                             mem_we,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_error
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW  = $clog2(LOCK_MAX + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(LOCK_MAX - 1);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_ARB    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]     r_state;
  logic [1:0]     w_next_state;
  logic [IDW-1:0] r_owner;
  logic [BW-1:0]  r_beats;
  logic           r_lock_timeout;
  logic           r_err;

  logic           w_any;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_sel;
  logic           w_granted;
  logic           w_release;
  logic           w_timeout;

  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [IDW-1:0]          r_pipe_id [READ_LATENCY];

  function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] i);
    return (i == IDW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Winner selection among asserted requests (only meaningful in ARB).
`ifdef MEM_ARB_RR_EN
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_idx;

  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
      w_idx = inc_id(w_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_state == ST_ARB && w_any) begin
      r_ptr <= inc_id(w_win);
    end else if (w_release) begin
      r_ptr <= inc_id(r_owner);
    end
  end
`else
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_any = 1'b1;
        w_win = IDW'(k);
      end
    end
  end
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    w_release    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_BOOT: begin
        if (boot_done) w_next_state = ST_ARB;
      end
      ST_ARB: begin
        if (w_any && lock[w_win]) begin
          if (LOCK_MAX > 1) w_next_state = ST_LOCKED;
          else              w_timeout    = 1'b1;
        end
      end
      ST_LOCKED: begin
        // A stalled owner (req low) keeps the lock regardless of its lock bit.
        if (req[r_owner]) begin
          if (!lock[r_owner]) begin
            w_release = 1'b1;
          end else if (r_beats == BEAT_LAST) begin
            w_release = 1'b1;
            w_timeout = 1'b1;
          end
        end
        if (w_release) w_next_state = ST_ARB;
      end
      default: w_next_state = ST_BOOT;
    endcase
  end

  // FSM: outputs (grant and memory command)
  always_comb begin
    gnt   = '0;
    w_sel = w_win;
    case (r_state)
      ST_ARB: begin
        if (w_any) gnt[w_win] = 1'b1;
      end
      ST_LOCKED: begin
        w_sel        = r_owner;
        gnt[r_owner] = req[r_owner];
      end
      default: gnt = '0;
    endcase
    w_granted = |gnt;

    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (w_granted) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_sel == IDW'(k)) begin
          mem_addr  = addr[k*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata = wdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      mem_we = we[w_sel];
      mem_re = ~we[w_sel];
    end
  end

  // Burst ownership, beat count, timeout pulse and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner        <= '0;
      r_beats        <= '0;
      r_lock_timeout <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_lock_timeout <= w_timeout;
      if (mem_error) r_err <= 1'b1;
      if (r_state == ST_ARB && w_any && lock[w_win]) begin
        r_owner <= w_win;
        r_beats <= BW'(1);
      end else if (r_state == ST_LOCKED && req[r_owner]) begin
        r_beats <= r_beats + 1'b1;
      end
    end
  end

  // Read-return tracking: one slot per cycle of memory latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pipe_id[i] <= '0;
    end else begin
      r_pipe_vld[0] <= mem_re;
      r_pipe_id[0]  <= w_sel;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_id[i]  <= r_pipe_id[i-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (r_pipe_vld[READ_LATENCY-1]) begin
      rvalid[r_pipe_id[READ_LATENCY-1]] = 1'b1;
      rdata = mem_rdata;
    end
  end

  assign lock_timeout = r_lock_timeout;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter: directed self-checking bench for mem_arbiter.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        boot_done;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [2:0]  lock;
  logic [15:0] a  [3];
  logic [15:0] wd [3];
  logic [47:0] addr;
  logic [47:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [15:0] rdata;
  logic        lock_timeout;
  logic        err;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_error;

  int total = 0;
  int bad   = 0;

  assign addr  = {a[2], a[1], a[0]};
  assign wdata = {wd[2], wd[1], wd[0]};

  mem_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .NUM_REQ(3), .READ_LATENCY(2), .LOCK_MAX(8)
  ) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done),
    .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .lock_timeout(lock_timeout), .err(err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_error(mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: two-cycle read latency, word 'h10 preloaded with 'h0003.
  logic [15:0] mem [256];
  logic [15:0] rd1, rd2;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 16'h0003 : 16'h0000;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    rd1 <= mem[mem_addr[7:0]];
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; boot_done = 1'b0; req = '0; we = '0; lock = '0; mem_error = 1'b0;
    for (int i = 0; i < 3; i++) begin a[i] = '0; wd[i] = '0; end
    cyc(); cyc();
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_cmd", {mem_re, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_flags", {lock_timeout, err}, 0);
    rst = 1'b0;
    cyc();

    // Boot gating: requests held while boot_done is low.
    req = 3'b011;
    for (int k = 0; k < 5; k++) begin
      #2; chk("boot_hold", gnt, 0);
      cyc();
    end
    boot_done = 1'b1;
    #2; chk("boot_edge", gnt, 0);
    cyc();
    #2; chk("boot_first", gnt, 3'b001); chk("boot_re", mem_re, 1);
    cyc();
    #2; chk("boot_second", gnt, RR ? 3'b010 : 3'b001);
    cyc();
    req = '0;
    cyc(); cyc(); cyc();

    // Read return routed to requester 0 after two cycles.
    req = 3'b001; a[0] = 16'h0010;
    #2; chk("rd_gnt", gnt, 3'b001); chk("rd_addr", mem_addr, 16'h0010); chk("rd_re", mem_re, 1);
    cyc();
    req = '0;
    #2; chk("rd_early", rvalid, 0);
    cyc();
    #2; chk("rd_valid", rvalid, 3'b001); chk("rd_data", rdata, 16'h0003);
    cyc();
    #2; chk("rd_once", rvalid, 0);

    // Locked five-beat push by requester 1 while requester 0 waits.
    for (int k = 0; k < 5; k++) begin
      req = (k == 0) ? 3'b010 : 3'b011;
      we = 3'b010;
      lock = (k < 4) ? 3'b010 : 3'b000;
      a[1] = 16'h0050 + 16'(k);
      wd[1] = 16'h00A0 + 16'(k);
      #2;
      chk("push_gnt", gnt, 3'b010);
      chk("push_we", {mem_we, mem_re}, 2'b10);
      chk("push_addr", mem_addr, 16'h0050 + 16'(k));
      cyc();
    end
    req = 3'b001; we = '0; lock = '0;
    #2; chk("push_after", gnt, 3'b001);
    cyc();
    req = '0;
    cyc(); cyc(); cyc();
    chk("push_mem52", mem[8'h52], 16'h00A2);
    chk("push_mem54", mem[8'h54], 16'h00A4);

    // Sticky error.
    mem_error = 1'b1;
    cyc();
    mem_error = 1'b0;
    #2; chk("err_set", err, 1);
    cyc();
    #2; chk("err_sticky", err, 1);
    cyc();

    // Lock timeout after eight beats; requester 2 also waiting.
    req = 3'b110; we = 3'b010; lock = 3'b010;
    for (int k = 0; k < 8; k++) begin
      a[1] = 16'h0060 + 16'(k);
      #2; chk("to_gnt", gnt, 3'b010); chk("to_quiet", lock_timeout, 0);
      cyc();
    end
    #2; chk("to_pulse", lock_timeout, 1); chk("to_next", gnt, RR ? 3'b100 : 3'b010);
    cyc();
    lock = '0;
    #2; chk("to_pulse_end", lock_timeout, 0); chk("to_release", gnt, 3'b010);
    cyc();
    req = '0; we = '0;
    cyc(); cyc(); cyc();

    // Reset with two reads in flight.
    req = 3'b001; a[0] = 16'h0010;
    cyc(); cyc();
    rst = 1'b1; req = '0; boot_done = 1'b0;
    cyc();
    rst = 1'b0; req = 3'b001;
    #2; chk("rr_rst_rvalid", rvalid, 0); chk("rr_rst_err", err, 0); chk("rr_rst_boot", gnt, 0);
    cyc();
    #2; chk("rr_rst_rvalid2", rvalid, 0); chk("rr_rst_boot2", gnt, 0);
    boot_done = 1'b1;
    cyc();

    // Arbitration with all three requesting.
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #2; chk("arb_seq", gnt, RR ? (3'b001 << (k % 3)) : 3'b001);
      cyc();
    end
    req = '0;
    cyc(); cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single `memory_controller` port between the core's memory clients: fetch FSM, heap write/CLINK-push FSM, and future GC or debug readers. It grants one access per cycle. It supports locked bursts so a multi-word CLINK push (header, return, func, args, prev) lands contiguously without interleaving. It tracks outstanding reads and routes returned data back to the issuing requester. It sits between the core's FSMs and `memory_controller` and replaces the ad-hoc read/write address mux.

## Interface
Parameters:
- `ADDR_WIDTH`, default `lisp::addr_width`: memory address width.
- `DATA_WIDTH`, default `lisp::data_width`: memory word width.
- `NUM_REQ`, default 3: number of requesters (index 0 = fetch, 1 = write, 2 = spare).
- `READ_LATENCY`, default 2: cycles from a granted read to valid `mem_rdata`. Matches the current REQ/STORE timing.
- `LOCK_MAX`, default 8: maximum beats in one locked burst.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `boot_done` in 1: memory initialisation complete.
- `req` in NUM_REQ: access request, one bit per requester.
- `we` in NUM_REQ: 1 = write, 0 = read, per requester.
- `lock` in NUM_REQ: hold the grant after this beat.
- `addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i uses slice i.
- `wdata` in NUM_REQ*DATA_WIDTH: packed write data.
- `gnt` out NUM_REQ: one-hot; the access is performed in the cycle `req[i] & gnt[i]`.
- `rvalid` out NUM_REQ: one-hot; read data valid for requester i.
- `rdata` out DATA_WIDTH: read data, broadcast to all requesters.
- `lock_timeout` out 1: one-cycle pulse when a burst is force-released.
- `err` out 1: sticky memory error.
- `mem_addr` out ADDR_WIDTH, `mem_re` out 1, `mem_we` out 1, `mem_wdata` out DATA_WIDTH: memory command.
- `mem_rdata` in DATA_WIDTH, `mem_error` in 1: memory response.

## Operation
States:
- **BOOT** (reset state): no grants. Move to ARB on `boot_done`.
- **ARB**: grant the winner among asserted `req`.
  - If the winner also asserts `lock`, move to LOCKED with `owner` = winner and `beats` = 1.
- **LOCKED**: only `owner` can be granted; `gnt[owner]` = `req[owner]`. Each granted beat increments `beats`.
  - A beat with `lock[owner]` = 0 is served, then return to ARB.
  - A beat that makes `beats` = LOCK_MAX is served, then return to ARB and pulse `lock_timeout`.
  - While locked, an owner cycle with `req` = 0 stalls; the lock is held.

Command generation:
- A granted cycle drives `mem_addr`/`mem_wdata` from the winner's slice.
- It asserts `mem_we` if `we[i]`, otherwise `mem_re`.
- With no grant, the memory command is all zero.

Read tracking:
- A READ_LATENCY-deep shift register of {valid, id} records each granted read.
- At the output end it drives `rvalid[id]` = 1 and `rdata` = `mem_rdata`.
- Reads and writes may be issued back-to-back; in-order return is guaranteed.

Errors:
- `mem_error` sets `err`; only `rst` clears it.
- Arbitration continues after an error; the consumer decides whether to halt.

## Timing
- Reset values:
  - `gnt`, `rvalid`, `mem_re`, `mem_we`, `lock_timeout`, `err` = 0.
  - `mem_addr`, `mem_wdata`, `rdata` = 0.
  - State = BOOT; round-robin pointer = 0; read pipeline flushed.
- `gnt` is combinational from `req`, state and pointer. It has zero-cycle latency, so a requester sees the grant in the same cycle it asserts `req`.
- Read data: `rvalid[i]` is asserted exactly READ_LATENCY cycles after the grant edge. Sustained throughput is 1 access/cycle.
- A write completes in its grant cycle; no acknowledge beyond `gnt`.
- The round-robin pointer updates to (winner+1) mod NUM_REQ:
  - on every ARB-state grant;
  - on burst release, with owner as the winner.
- Requests in BOOT are held, not dropped.
- Reset mid-burst or with reads in flight: reset wins. The pipeline clears, and no `rvalid` follows reset.
- Simultaneous release and new request in the same cycle: the release beat is served. The new arbitration happens on the next cycle.
- `lock` asserted without `req` is ignored in ARB.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin search starting at the pointer.
- `MEM_ARB_RR_EN` undefined: fixed priority, lowest index wins (fetch over write). The pointer logic is not built.
- Lock, read tracking and error behaviour are identical in both builds.

## Test plan
- **Boot gating:** `req` = 3'b011 with `boot_done` low for 5 cycles → `gnt` = 0 throughout. After `boot_done`:
  - fixed priority: `gnt` = 3'b001 next cycle.
  - RR: `gnt` = 3'b001, then 3'b010.
- **Read return:** requester 0 reads addr 'h10, memory holds 'h0003 → exactly 2 cycles later `rvalid` = 3'b001 and `rdata` = 'h0003.
- **Locked push:** requester 1 issues 5 locked writes to 'h50–'h54 while requester 0 requests continuously → 5 consecutive `mem_we` beats, no interleave. Requester 0 is granted on the 6th cycle.
- **Lock timeout:** with LOCK_MAX = 8, requester 1 holds `lock` for 10 beats → 8 grants, then a `lock_timeout` pulse. In RR mode requester 2 (if requesting) wins next.
- **Round robin:** with RR enabled, `req` = 3'b111 for 6 cycles → `gnt` sequence 001, 010, 100, 001, 010, 100.
- **Error and reset:** pulse `mem_error` → `err` = 1 and stays high. Assert `rst` with 2 reads in flight → `err` = 0, no `rvalid` afterwards, state BOOT.
